// File: rtl/uart_loader_pkg.sv
// Shared loader definitions: default widths, record markers and FSM state encodings.
// Used by uart_loader (build option UART_LOADER_CHECKSUM_EN adds the ST_CHK state).
package uart_loader_pkg;

  localparam int          DEF_ADDR_W      = 12;
  localparam int          DEF_DATA_W      = 32;
  localparam logic [7:0]  DEF_SYNC_BYTE   = 8'h55;
  localparam logic [11:0] DEF_END_ADDR    = 12'hFFF;
  localparam int          DEF_TIMEOUT_CYC = 100000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHK   = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } ld_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags the
// cycle on which the count reaches TIMEOUT_CYC-1.
module loader_timeout #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // Expiry wins over a same-cycle clear, so a byte on that cycle is lost.
  assign expire = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || expire) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/uart_loader.sv
// UART image loader: parses SYNC/addr/data records into RAM writes and raises
// load_done on the END_ADDR record. Option macro: UART_LOADER_CHECKSUM_EN.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter logic [7:0]        SYNC_BYTE   = DEF_SYNC_BYTE,
  parameter logic [ADDR_W-1:0] END_ADDR    = ADDR_W'(DEF_END_ADDR),
  parameter int                TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              rearm,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              load_done,
  output logic [7:0]        err_count,
  output logic [2:0]        dbg_state
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BCNT_W = $clog2(NBYTES) + 1;
  localparam logic [BCNT_W-1:0] BCNT_ADDR_LAST = BCNT_W'(1);
  localparam logic [BCNT_W-1:0] BCNT_DATA_LAST = BCNT_W'(NBYTES - 1);
  localparam logic [BCNT_W-1:0] BCNT_ONE       = BCNT_W'(1);

  // Handshake: rx_ready is a one-cycle strobe qualifying rx_data; there is no
  // back-pressure, a byte not consumed in its strobe cycle is gone.
  ld_state_t         state, next_state;
  logic [BCNT_W-1:0] bcnt;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              timed, expire, err_inc;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]        chk_q;
`endif

  assign timed = (state == ST_ADDR) || (state == ST_DATA) || (state == ST_CHK);

  loader_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_ready || !timed),
    .enable (timed),
    .expire (expire)
  );

  always_comb begin
    next_state = state;
    err_inc    = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    if (rx_ready && (state == ST_ADDR)) addr_d = ADDR_W'({addr_q, rx_data});
    if (rx_ready && (state == ST_DATA)) data_d = DATA_W'({data_q, rx_data});
    case (state)
      ST_IDLE: begin
        if (rx_ready && (rx_data == SYNC_BYTE)) next_state = ST_ADDR;
      end
      ST_ADDR: begin
        if (expire) begin
          next_state = ST_IDLE;
          err_inc    = 1'b1;
        end else if (rx_ready && (bcnt == BCNT_ADDR_LAST)) begin
`ifdef UART_LOADER_CHECKSUM_EN
          next_state = (addr_d == END_ADDR) ? ST_CHK : ST_DATA;
`else
          next_state = (addr_d == END_ADDR) ? ST_DONE : ST_DATA;
`endif
        end
      end
      ST_DATA: begin
        if (expire) begin
          next_state = ST_IDLE;
          err_inc    = 1'b1;
        end else if (rx_ready && (bcnt == BCNT_DATA_LAST)) begin
`ifdef UART_LOADER_CHECKSUM_EN
          next_state = ST_CHK;
`else
          next_state = ST_WRITE;
`endif
        end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (expire) begin
          next_state = ST_IDLE;
          err_inc    = 1'b1;
        end else if (rx_ready) begin
          if (rx_data == chk_q) begin
            next_state = (addr_q == END_ADDR) ? ST_DONE : ST_WRITE;
          end else begin
            next_state = ST_IDLE;
            err_inc    = 1'b1;
          end
        end
      end
`endif
      ST_WRITE: begin
        next_state = (rx_ready && (rx_data == SYNC_BYTE)) ? ST_ADDR : ST_IDLE;
      end
      ST_DONE: begin
        if (rearm) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      bcnt      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err_count <= '0;
    end else begin
      state  <= next_state;
      addr_q <= addr_d;
      data_q <= data_d;
      if (next_state != state) begin
        bcnt <= '0;
      end else if (rx_ready && ((state == ST_ADDR) || (state == ST_DATA))) begin
        bcnt <= bcnt + BCNT_ONE;
      end
      // Write port registers only change on entry to WRITE, so they hold otherwise.
      if (next_state == ST_WRITE) begin
        mem_addr  <= addr_d;
        mem_wdata <= data_d;
      end
      if (err_inc) err_count <= sat_inc8(err_count);
    end
  end

`ifdef UART_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      chk_q <= '0;
    end else if ((next_state == ST_ADDR) && (state != ST_ADDR)) begin
      chk_q <= '0;
    end else if (rx_ready && ((state == ST_ADDR) || (state == ST_DATA))) begin
      chk_q <= chk_q ^ rx_data;
    end
  end
`endif

  assign mem_we    = (state == ST_WRITE);
  assign busy      = (state != ST_IDLE) && (state != ST_DONE);
  assign load_done = (state == ST_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: directed record scenarios plus randomized
// records, checked against a byte-level record parser model and a write queue.
module tb_uart_loader;
  import uart_loader_pkg::*;

  localparam int          AW   = 12;
  localparam int          DW   = 32;
  localparam int          TO   = 40;
  localparam logic [7:0]  SYNC = 8'h55;
  localparam logic [11:0] ENDA = 12'hFFF;
`ifdef UART_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef logic [7:0] bytes_t[$];

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready = 1'b0;
  logic          rearm = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we, busy, load_done;
  logic [7:0]    err_count;
  logic [2:0]    dbg_state;

  int total = 0;
  int bad   = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [7:0]       rec[$];
  logic             m_done = 1'b0;
  logic [7:0]       m_err  = 8'h00;

  uart_loader #(.TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .rearm     (rearm),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .busy      (busy),
    .load_done (load_done),
    .err_count (err_count),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model: record parser over the byte stream ----------------
  task automatic model_byte(input logic [7:0] b);
    logic [15:0] a16;
    logic [AW-1:0] a;
    logic [7:0] x;
    int need;
    if (m_done) return;
    if (rec.size() == 0) begin
      if (b == SYNC) rec.push_back(b);
      return;
    end
    rec.push_back(b);
    if (rec.size() < 3) return;
    a16  = {rec[1], rec[2]};
    a    = a16[AW-1:0];
    need = (a == ENDA) ? 3 : 3 + DW / 8;
    if (CHK_EN) need++;
    if (rec.size() < need) return;
    if (CHK_EN) begin
      x = 8'h00;
      for (int i = 1; i < need - 1; i++) x ^= rec[i];
      if (x != rec[need-1]) begin
        if (m_err != 8'hFF) m_err++;
        rec.delete();
        return;
      end
    end
    if (a == ENDA) m_done = 1'b1;
    else exp_q.push_back({a, rec[3], rec[4], rec[5], rec[6]});
    rec.delete();
  endtask

  task automatic model_timeout();
    rec.delete();
    if (m_err != 8'hFF) m_err++;
  endtask

  function automatic bytes_t rec_bytes(input logic [11:0] a, input logic [31:0] d, input bit is_end);
    bytes_t s;
    logic [15:0] a16;
    logic [7:0] x;
    a16 = {4'h0, a};
    s.push_back(SYNC);
    s.push_back(a16[15:8]);
    s.push_back(a16[7:0]);
    x = a16[15:8] ^ a16[7:0];
    if (!is_end) begin
      for (int i = 3; i >= 0; i--) begin
        s.push_back(d[i*8 +: 8]);
        x ^= d[i*8 +: 8];
      end
    end
    if (CHK_EN) s.push_back(x);
    return s;
  endfunction

  // ---------------- scoreboard on the write port ----------------
  always @(negedge clk) begin
    if (reset && mem_we) begin
      check("write_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e[AW+DW-1:DW]));
        check("wr_data", 64'(mem_wdata), 64'(e[DW-1:0]));
      end
    end
  end

  // ---------------- driver tasks (called at #1 after a rising edge) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic send_seq(input bytes_t s, input int gap_max);
    foreach (s[i]) begin
      if (i != 0) idle($urandom_range(gap_max, 0));
      send_byte(s[i]);
    end
  endtask

  task automatic pulse_rearm();
    rearm = 1'b1;
    @(posedge clk);
    #1;
    rearm = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    bytes_t s;
    logic [11:0] a;
    logic [31:0] d;
    logic [7:0] junk;
    int k;

    reset = 1'b0;
    idle(3);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(load_done), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    reset = 1'b1;
    idle(2);

    // Basic write, latency and busy
    send_seq(rec_bytes(12'h010, 32'hDEADBEEF, 1'b0), 0);
    check("t1_we", 64'(mem_we), 64'd1);
    check("t1_addr", 64'(mem_addr), 64'h010);
    check("t1_data", 64'(mem_wdata), 64'hDEADBEEF);
    check("t1_busy_wr", 64'(busy), 64'd1);
    idle(1);
    check("t1_we_low", 64'(mem_we), 64'd0);
    check("t1_busy_low", 64'(busy), 64'd0);
    check("t1_hold_data", 64'(mem_wdata), 64'hDEADBEEF);
    idle(3);

    // END record, ignored traffic, rearm
    send_seq(rec_bytes(ENDA, 32'h0, 1'b1), 1);
    check("t2_done", 64'(load_done), 64'(m_done));
    check("t2_busy", 64'(busy), 64'd0);
    s = '{8'h55, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send_seq(s, 1);
    idle(2);
    check("t2_done_hold", 64'(load_done), 64'd1);
    pulse_rearm();
    m_done = 1'b0;
    check("t2_rearm", 64'(load_done), 64'd0);
    check("t2_state", 64'(dbg_state), 64'(ST_IDLE));

    // rearm mid-record has no effect
    s = rec_bytes(12'h040, 32'hCAFEF00D, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(s[i]);
    pulse_rearm();
    for (int i = 3; i < s.size(); i++) send_byte(s[i]);
    idle(2);
    check("t2b_q", 64'(exp_q.size()), 64'd0);

    // Timeout inside a record, one cycle either side of the limit
    s = '{8'h55, 8'h00, 8'h20, 8'hAA};
    send_seq(s, 0);
    idle(TO - 1);
    check("t3_err_before", 64'(err_count), 64'd0);
    check("t3_busy_before", 64'(busy), 64'd1);
    idle(1);
    model_timeout();
    check("t3_err", 64'(err_count), 64'(m_err));
    check("t3_state", 64'(dbg_state), 64'(ST_IDLE));
    send_seq(rec_bytes(12'h021, 32'h13579BDF, 1'b0), 2);
    idle(2);

    // Leading junk then a record
    s = '{8'h12, 8'h34};
    send_seq(s, 0);
    send_seq(rec_bytes(12'h005, 32'h01020304, 1'b0), 0);
    check("t4_addr", 64'(mem_addr), 64'h005);
    check("t4_data", 64'(mem_wdata), 64'h01020304);
    idle(2);

`ifdef UART_LOADER_CHECKSUM_EN
    s = '{8'h55, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    send_seq(s, 0);
    check("c_we", 64'(mem_we), 64'd1);
    check("c_data", 64'(mem_wdata), 64'h1);
    idle(2);
    s = '{8'h55, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
    send_seq(s, 0);
    check("c_bad_we", 64'(mem_we), 64'd0);
    check("c_bad_err", 64'(err_count), 64'(m_err));
    idle(2);
`endif

    // Saturation of the error counter
    for (int i = 0; i < 260; i++) begin
      send_byte(SYNC);
      idle(TO);
      model_timeout();
      check("sat_err", 64'(err_count), 64'(m_err));
    end
    check("sat_ff", 64'(err_count), 64'hFF);

    // Reset mid-record
    s = '{8'h55, 8'h00, 8'h30, 8'h11};
    send_seq(s, 0);
    #2;
    reset = 1'b0;
    #1;
    rec.delete();
    m_err  = 8'h00;
    m_done = 1'b0;
    check("t5_addr", 64'(mem_addr), 64'd0);
    check("t5_data", 64'(mem_wdata), 64'd0);
    check("t5_we", 64'(mem_we), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(load_done), 64'd0);
    check("t5_err", 64'(err_count), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);
    send_seq(rec_bytes(12'h030, 32'h11223344, 1'b0), 0);
    check("t5_rewrite", 64'(mem_wdata), 64'h11223344);
    idle(2);

    // Randomized records, junk and truncated records
    for (int r = 0; r < 40; r++) begin
      k = $urandom_range(2, 0);
      for (int j = 0; j < k; j++) begin
        junk = 8'($urandom_range(255, 0));
        if (junk == SYNC) junk = 8'h00;
        send_byte(junk);
        idle($urandom_range(3, 0));
      end
      a = 12'($urandom_range(4095, 0));
      if (a == ENDA) a = 12'h000;
      d = $urandom;
      s = rec_bytes(a, d, 1'b0);
      if ($urandom_range(7, 0) == 0) begin
        k = $urandom_range(s.size() - 1, 1);
        for (int i = 0; i < k; i++) send_byte(s[i]);
        idle(TO + 3);
        model_timeout();
        check("rnd_to_err", 64'(err_count), 64'(m_err));
      end else begin
        send_seq(s, 4);
        idle($urandom_range(3, 0));
      end
    end
    idle(3);
    check("rnd_q_empty", 64'(exp_q.size()), 64'd0);
    check("rnd_err", 64'(err_count), 64'(m_err));

    send_seq(rec_bytes(ENDA, 32'h0, 1'b1), 2);
    idle(1);
    check("end_done", 64'(load_done), 64'(m_done));
    check("end_q_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
